// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbiter_if
//  Description : Bundle of the two host request ports and the SDRAM
//                controller command/response signals around sdram_arbiter.
//                slave  - the arbiter's view (hosts + controller drive it)
//                master - the environment's view (hosts + controller model)
//  Ports       : p0_/p1_ req, we, addr, wdata, ack, rdata    (host side)
//                wr_addr, rd_addr, wr_data, wr_enable, rd_enable,
//                rd_data, rd_ready, busy                      (controller side)
//                gnt                                          (status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if #(
    parameter int HADDR_WIDTH = 25
);
    // host port 0
    logic                   p0_req;
    logic                   p0_we;
    logic [HADDR_WIDTH-1:0] p0_addr;
    logic [7:0]             p0_wdata;
    logic                   p0_ack;
    logic [7:0]             p0_rdata;
    // host port 1
    logic                   p1_req;
    logic                   p1_we;
    logic [HADDR_WIDTH-1:0] p1_addr;
    logic [7:0]             p1_wdata;
    logic                   p1_ack;
    logic [7:0]             p1_rdata;
    // controller side
    logic [HADDR_WIDTH-1:0] wr_addr;
    logic [HADDR_WIDTH-1:0] rd_addr;
    logic [7:0]             wr_data;
    logic                   wr_enable;
    logic                   rd_enable;
    logic [7:0]             rd_data;
    logic                   rd_ready;
    logic                   busy;
    // status
    logic                   gnt;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  rd_data, rd_ready, busy,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output wr_addr, rd_addr, wr_data, wr_enable, rd_enable, gnt
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output rd_data, rd_ready, busy,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  wr_addr, rd_addr, wr_data, wr_enable, rd_enable, gnt
    );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbiter
//  Description : Two-port round-robin arbiter in front of a single-command
//                SDRAM controller. One transaction is outstanding at a time:
//                IDLE (arbitrate + latch) -> ISSUE (strobe enable until the
//                controller reports busy) -> WAIT (read: rd_ready, write:
//                busy low) -> DONE (one-cycle ack to the granted port).
//  Ports       : clk    - system clock, all state on posedge
//                rst_n  - synchronous active-low reset
//                bus    - sdram_arbiter_if.slave (host ports + controller)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int HADDR_WIDTH = 25
) (
    input  wire            clk,
    input  wire            rst_n,
    sdram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_gnt;
    logic                   r_we;
    logic [HADDR_WIDTH-1:0] r_addr;
    logic [7:0]             r_wdata;
    logic [7:0]             r_rdata0;
    logic [7:0]             r_rdata1;

    logic                   w_sel;
    logic                   w_latch;
    logic                   w_capture;
    logic                   w_rd_en;
    logic                   w_wr_en;
    logic                   w_ack0;
    logic                   w_ack1;

    // Round-robin pick: on a tie the port that was not granted last wins.
    // r_gnt resets to 1 so port 0 takes the first tie.
    always_comb begin
        w_sel = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            w_sel = ~r_gnt;
        end else begin
            w_sel = bus.p1_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        w_rd_en   = 1'b0;
        w_wr_en   = 1'b0;
        w_ack0    = 1'b0;
        w_ack1    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((bus.p0_req || bus.p1_req) && !bus.busy) begin
                    w_latch = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Keep strobing until the controller has picked the command up;
                // a controller that never goes busy parks us here.
                w_rd_en = ~r_we;
                w_wr_en = r_we;
                if (bus.busy) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_we) begin
                    // rd_ready is meaningless for a write and is ignored
                    if (!bus.busy) begin
                        w_next = S_DONE;
                    end
                end else if (bus.rd_ready) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_ack0 = ~r_gnt;
                w_ack1 = r_gnt;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Transaction latch and per-port read data. The latched command stays
    // put after a req is withdrawn early, so the transaction still finishes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt    <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_latch) begin
                r_gnt   <= w_sel;
                r_we    <= w_sel ? bus.p1_we    : bus.p0_we;
                r_addr  <= w_sel ? bus.p1_addr  : bus.p0_addr;
                r_wdata <= w_sel ? bus.p1_wdata : bus.p0_wdata;
            end
            if (w_capture) begin
                if (r_gnt) begin
                    r_rdata1 <= bus.rd_data;
                end else begin
                    r_rdata0 <= bus.rd_data;
                end
            end
        end
    end

    // Both address buses always carry the latched address so the
    // controller never latches a stale value on either path.
    assign bus.rd_addr   = r_addr;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = r_wdata;
    assign bus.rd_enable = w_rd_en;
    assign bus.wr_enable = w_wr_en;
    assign bus.p0_ack    = w_ack0;
    assign bus.p1_ack    = w_ack1;
    assign bus.p0_rdata  = r_rdata0;
    assign bus.p1_rdata  = r_rdata1;
    assign bus.gnt       = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_arbiter
//  Description : Self-checking bench for sdram_arbiter with a behavioural
//                SDRAM controller model and scoreboard queues for host acks
//                and controller commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int AW = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sdram_arbiter_if #(.HADDR_WIDTH(AW)) bus ();

    sdram_arbiter #(.HADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] rdata;
    } ack_exp_t;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } cmd_t;

    ack_exp_t q_ack0[$];
    ack_exp_t q_ack1[$];
    cmd_t     q_cmd[$];

    logic [7:0] mem [bit [AW-1:0]];

    logic       force_busy = 1'b0;
    logic       spur_en    = 1'b0;
    logic [7:0] last0      = 8'h00;
    logic [7:0] last1      = 8'h00;

    // ---------------- scoreboard helpers ----------------
    task automatic push_cmd(input logic port, input logic we, input logic [AW-1:0] addr,
                            input logic [7:0] data);
        cmd_t c;
        c.port = port; c.we = we; c.addr = addr; c.data = data;
        q_cmd.push_back(c);
    endtask

    task automatic push_ack(input logic port, input logic we, input logic [7:0] exp);
        ack_exp_t e;
        e.we = we; e.rdata = exp;
        if (port) q_ack1.push_back(e);
        else      q_ack0.push_back(e);
    endtask

    task automatic set_req(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [7:0] wdata);
        if (port) begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
        end else begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
        end
    endtask

    task automatic drop_req(input logic port);
        if (port) bus.p1_req = 1'b0;
        else      bus.p0_req = 1'b0;
    endtask

    task automatic wait_ack(input logic port, input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (port ? bus.p1_ack : bus.p0_ack) return;
        end
        check_eq({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.busy) return;
        end
        check_eq({tag, "_busy_timeout"}, 32'd0, 32'd1);
    endtask

    // Full single transaction on one port.
    task automatic do_xfer(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [7:0] data, input string tag);
        push_cmd(port, we, addr, data);
        push_ack(port, we, data);
        @(posedge clk); #1;
        set_req(port, we, addr, data);
        wait_ack(port, tag);
        drop_req(port);
    endtask

    // ---------------- SDRAM controller model ----------------
    // Accepts a command, holds busy for 4 cycles, pulses rd_ready one cycle
    // before busy falls on reads (optionally a spurious one on writes).
    initial begin : ctl_model
        int            cnt;
        logic          rd;
        logic          cbusy;
        logic [AW-1:0] caddr;
        cmd_t          c;
        cnt = 0; rd = 1'b0; cbusy = 1'b0; caddr = '0;
        bus.busy = 1'b0; bus.rd_ready = 1'b0; bus.rd_data = 8'h00;
        forever begin
            @(negedge clk);
            bus.rd_ready = 1'b0;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 1) begin
                    if (rd) begin
                        bus.rd_ready = 1'b1;
                        bus.rd_data  = mem.exists(caddr) ? mem[caddr] : 8'h00;
                    end else if (spur_en) begin
                        bus.rd_ready = 1'b1;
                        bus.rd_data  = 8'hEE;
                    end
                end
                if (cnt == 0) cbusy = 1'b0;
            end else if (!force_busy && (bus.rd_enable || bus.wr_enable)) begin
                if (q_cmd.size() == 0) begin
                    check_eq("cmd_unexpected", 32'd1, 32'd0);
                end else begin
                    c = q_cmd.pop_front();
                    check_eq("cmd_port", 32'(bus.gnt), 32'(c.port));
                    check_eq("cmd_we", 32'(bus.wr_enable), 32'(c.we));
                    check_eq("cmd_addr", 32'(bus.rd_addr), 32'(c.addr));
                    if (c.we) check_eq("cmd_wdata", 32'(bus.wr_data), 32'(c.data));
                end
                rd    = bus.rd_enable;
                caddr = bus.rd_addr;
                if (bus.wr_enable) mem[bus.wr_addr] = bus.wr_data;
                cnt   = 4;
                cbusy = 1'b1;
            end
            bus.busy = cbusy | force_busy;
        end
    end

    // Reset clears both rdata registers.
    initial begin : rst_track
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                last0 = 8'h00;
                last1 = 8'h00;
            end
        end
    end

    // ---------------- output monitor ----------------
    task automatic handle_ack(input logic port);
        ack_exp_t e;
        if ((port ? q_ack1.size() : q_ack0.size()) == 0) begin
            check_eq(port ? "p1_ack_unexpected" : "p0_ack_unexpected", 32'd1, 32'd0);
        end else begin
            e = port ? q_ack1.pop_front() : q_ack0.pop_front();
            if (!e.we) begin
                check_eq(port ? "p1_rdata" : "p0_rdata",
                         32'(port ? bus.p1_rdata : bus.p0_rdata), 32'(e.rdata));
                if (port) last1 = e.rdata;
                else      last0 = e.rdata;
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.p0_ack && bus.p1_ack) check_eq("ack_both", 32'd1, 32'd0);
                if (bus.p0_ack) handle_ack(1'b0);
                if (bus.p1_ack) handle_ack(1'b1);
                if (bus.rd_enable || bus.wr_enable) begin
                    check_eq("en_excl", 32'(bus.rd_enable & bus.wr_enable), 32'd0);
                    check_eq("addr_match", 32'(bus.wr_addr), 32'(bus.rd_addr));
                end
                check_eq("p0_rdata_hold", 32'(bus.p0_rdata), 32'(last0));
                check_eq("p1_rdata_hold", 32'(bus.p1_rdata), 32'(last1));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"},       32'(bus.gnt),       32'd1);
        check_eq({tag, "_p0_ack"},    32'(bus.p0_ack),    32'd0);
        check_eq({tag, "_p1_ack"},    32'(bus.p1_ack),    32'd0);
        check_eq({tag, "_rd_en"},     32'(bus.rd_enable), 32'd0);
        check_eq({tag, "_wr_en"},     32'(bus.wr_enable), 32'd0);
        check_eq({tag, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
        check_eq({tag, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
        check_eq({tag, "_wr_data"},   32'(bus.wr_data),   32'd0);
        check_eq({tag, "_p0_rdata"},  32'(bus.p0_rdata),  32'd0);
        check_eq({tag, "_p1_rdata"},  32'(bus.p1_rdata),  32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic en_seen;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = 8'h00;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = 8'h00;
        mem[25'h0000123] = 8'h5A;
        mem[25'h0000040] = 8'h3C;
        mem[25'h0000050] = 8'h77;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // p0 read 0x123 -> 0x5A, enable one cycle after req is sampled
        push_cmd(1'b0, 1'b0, 25'h0000123, 8'h00);
        push_ack(1'b0, 1'b0, 8'h5A);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 25'h0000123, 8'h00);
        @(negedge clk);
        check_eq("lat_pre_rd_en", 32'(bus.rd_enable), 32'd0);
        @(negedge clk);
        check_eq("lat_rd_en", 32'(bus.rd_enable), 32'd1);
        check_eq("lat_rd_addr", 32'(bus.rd_addr), 32'h123);
        wait_ack(1'b0, "t1");
        drop_req(1'b0);
        check_eq("t1_p0_rdata", 32'(bus.p0_rdata), 32'h5A);

        // p1 read, leaves gnt = 1
        do_xfer(1'b1, 1'b0, 25'h0000050, 8'h77, "t1b");

        // simultaneous writes: p0 first, then p1
        push_cmd(1'b0, 1'b1, 25'h0000010, 8'h11);
        push_cmd(1'b1, 1'b1, 25'h0000020, 8'h22);
        push_ack(1'b0, 1'b1, 8'h11);
        push_ack(1'b1, 1'b1, 8'h22);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 25'h0000010, 8'h11);
        set_req(1'b1, 1'b1, 25'h0000020, 8'h22);
        fork
            begin wait_ack(1'b0, "t2p0"); drop_req(1'b0); end
            begin wait_ack(1'b1, "t2p1"); drop_req(1'b1); end
        join
        @(negedge clk);
        check_eq("t2_gnt", 32'(bus.gnt), 32'd1);

        // read back a written location
        do_xfer(1'b0, 1'b0, 25'h0000010, 8'h11, "t2rb");

        // p1 holds req for 4 reads, p0 asks once: p0 must be second
        push_cmd(1'b1, 1'b0, 25'h0000050, 8'h00);
        push_cmd(1'b0, 1'b0, 25'h0000040, 8'h00);
        push_cmd(1'b1, 1'b0, 25'h0000050, 8'h00);
        push_cmd(1'b1, 1'b0, 25'h0000050, 8'h00);
        push_cmd(1'b1, 1'b0, 25'h0000050, 8'h00);
        for (int k = 0; k < 4; k++) push_ack(1'b1, 1'b0, 8'h77);
        push_ack(1'b0, 1'b0, 8'h3C);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 25'h0000050, 8'h00);
        fork
            begin
                for (int k = 0; k < 4; k++) wait_ack(1'b1, "t3p1");
                drop_req(1'b1);
            end
            begin
                wait_busy("t3");
                set_req(1'b0, 1'b0, 25'h0000040, 8'h00);
                wait_ack(1'b0, "t3p0");
                drop_req(1'b0);
            end
        join
        check_eq("t3_q_cmd_empty", 32'(q_cmd.size()), 32'd0);

        // controller busy for 50 cycles at request time
        push_cmd(1'b0, 1'b0, 25'h0000123, 8'h00);
        push_ack(1'b0, 1'b0, 8'h5A);
        @(posedge clk); #1;
        force_busy = 1'b1;
        set_req(1'b0, 1'b0, 25'h0000123, 8'h00);
        en_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rd_enable || bus.wr_enable) en_seen = 1'b1;
        end
        check_eq("t4_no_en_while_busy", 32'(en_seen), 32'd0);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_ack(1'b0, "t4");
        drop_req(1'b0);

        // reset during WAIT of a read: no ack, reset values next cycle
        push_cmd(1'b0, 1'b0, 25'h0000040, 8'h00);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 25'h0000040, 8'h00);
        wait_busy("t5");
        rst_n = 1'b0;
        drop_req(1'b0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t5_abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_xfer(1'b0, 1'b0, 25'h0000040, 8'h3C, "t5_after");
        check_eq("t5_p0_rdata", 32'(bus.p0_rdata), 32'h3C);

        // spurious rd_ready during a write
        spur_en = 1'b1;
        do_xfer(1'b1, 1'b1, 25'h0000060, 8'h99, "t6");
        spur_en = 1'b0;
        @(negedge clk);
        check_eq("t6_p0_rdata", 32'(bus.p0_rdata), 32'h3C);
        check_eq("t6_p1_rdata", 32'(bus.p1_rdata), 32'h00);
        do_xfer(1'b0, 1'b0, 25'h0000060, 8'h99, "t6rb");

        repeat (6) @(posedge clk);
        check_eq("end_q_ack0_empty", 32'(q_ack0.size()), 32'd0);
        check_eq("end_q_ack1_empty", 32'(q_ack1.size()), 32'd0);
        check_eq("end_q_cmd_empty",  32'(q_cmd.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter HADDR_WIDTH, default 25: host address width, equal to the sdram_controller bank+row+column width.
REQ-002 Clocking and reset: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-003 clk  input  1  system clock, all state on posedge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 p0_req / p1_req  input  1  port request, held until that port's ack.
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read, stable while req is high.
REQ-007 p0_addr / p1_addr  input  HADDR_WIDTH  target address, stable while req is high.
REQ-008 p0_wdata / p1_wdata  input  8  write data, stable while req is high.
REQ-009 p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-010 p0_rdata / p1_rdata  output  8  read data, valid in the ack cycle of a read and held until that port's next read completes.
REQ-011 wr_addr, rd_addr  output  HADDR_WIDTH  address driven to the controller.
REQ-012 wr_data  output  8  write data driven to the controller.
REQ-013 wr_enable, rd_enable  output  1  controller command strobes.
REQ-014 rd_data  input  8  controller read data.
REQ-015 rd_ready  input  1  controller read-valid pulse.
REQ-016 busy  input  1  controller busy flag, high while a read/write sequence is running.
REQ-017 gnt  output  1  index of the port currently or last granted.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE; only one transaction is outstanding at a time.
REQ-019 IDLE: when any req is high and busy is low, select a port, latch its we/addr/wdata, update gnt, go to ISSUE next cycle; if busy is high, stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: if both reqs are high, grant the port not equal to gnt; if one req is high, grant that port.
REQ-021 ISSUE: assert rd_enable (read) or wr_enable (write) every cycle, with the latched address on rd_addr/wr_addr and the latched data on wr_data; go to WAIT on the first cycle busy is sampled high.
REQ-022 Exactly one of rd_enable/wr_enable SHALL be high, and only in ISSUE; both are low in every other state.
REQ-023 WAIT, read: on rd_ready high, capture rd_data into the granted port's rdata register and go to DONE.
REQ-024 WAIT, write: on busy sampled low, go to DONE.
REQ-025 DONE: pulse the granted port's ack for exactly one cycle, return to IDLE; the other ack stays low.
REQ-026 Minimum latency with an idle controller: rd_enable/wr_enable rises 1 cycle after req is sampled.
REQ-027 Back-to-back: the next grant is evaluated in the cycle after DONE; a port's req held high after its ack is treated as a new request.
REQ-028 A req deasserted before ack is a protocol violation; the latched transaction SHALL still complete and ack SHALL still pulse.
REQ-029 rd_ready seen in ISSUE, IDLE, or during a write SHALL be ignored.
REQ-030 rd_addr and wr_addr SHALL both carry the latched address in all states, so the controller's internal address latch never sees a stale value.
REQ-031 No counters wrap; the design has no timeout, and a controller that never asserts busy holds the FSM in ISSUE.

Reset
REQ-032 While rst_n is low at a clk edge: state IDLE, gnt 1 (so port 0 wins the first tie), acks 0, enables 0, rd_addr/wr_addr/wr_data 0, both rdata 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack, dropping enables on the next edge.

Verification
REQ-034 After reset, p0 read addr 0x0000123 with controller model returning 0x5A -> rd_enable high with rd_addr 0x0000123 until busy; p0_ack pulses once; p0_rdata = 0x5A; p1_ack stays 0.
REQ-035 p0 and p1 writes requested in the same cycle (p0 0x11 @0x10, p1 0x22 @0x20) -> p0 is served first, then p1; wr_data sequence is 0x11, 0x22; gnt ends at 1.
REQ-036 p1 holds req continuously for 4 reads while p0 requests once -> the p0 grant is interleaved no later than after p1's next completion.
REQ-037 busy held high for 50 cycles at request time -> no enable until busy falls, then normal completion.
REQ-038 rst_n pulled low during WAIT of a read -> no ack, all outputs at reset values next cycle; a subsequent read completes normally.
REQ-039 Spurious rd_ready during a write -> neither rdata changes; the write acks on busy fall.
